mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
// mul_div_unit: iterative 32-bit multiply/divide unit.
// MULTU/MULT use shift-add (one multiplier bit per cycle), DIVU/DIV use
// restoring division (one quotient bit per cycle). Signed ops run on
// magnitudes and fix signs when the result is written. Every operation
// takes exactly 32 RUN cycles followed by one DONE cycle.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd31;

   // Magnitude of an operand: negate only when the op is signed and v < 0.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
      logic [31:0] m;
      if (is_signed && v[31]) begin
         m = 32'd0 - v;
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Two's-complement negation, 32 bits.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return 32'd0 - v;
   endfunction

   // Two's-complement negation, 64 bits.
   function automatic logic [63:0] neg64(input logic [63:0] v);
      return 64'd0 - v;
   endfunction

   state_t      state_r;
   state_t      next_state_s;
   logic        load_s;
   logic        step_s;
   logic        finish_s;

   logic [4:0]  cnt_r;
   logic [1:0]  op_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   // acc_r: multiply -> {partial product, remaining multiplier bits}
   //        divide   -> {partial remainder, dividend/quotient bits}
   logic [63:0] acc_r;
   // opnd_r: multiplicand magnitude (multiply) or divisor magnitude (divide)
   logic [31:0] opnd_r;

   logic [32:0] mul_sum_s;
   logic [64:0] div_shl_s;
   logic [32:0] div_diff_s;
   logic [63:0] acc_next_s;

   logic [63:0] prod_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] res_hi_s;
   logic [31:0] res_lo_s;

   logic        busy_r;
   logic        done_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      step_s       = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_RUN;
               load_s       = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            step_s = 1'b1;
            if (cnt_r == LAST_STEP) begin
               next_state_s = ST_DONE;
               finish_s     = 1'b1;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) begin
               next_state_s = ST_RUN;
               load_s       = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // One iteration: shift-add for multiply, trial subtract for divide.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[63:32]};
      div_shl_s  = {acc_r, 1'b0};
      div_diff_s = div_shl_s[64:32] - {1'b0, opnd_r};
      acc_next_s = acc_r;
      if (acc_r[0]) begin
         mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[63:32]};
      end
      if (op_r[1]) begin
         // No borrow means the shifted remainder covers the divisor.
         if (!div_diff_s[32]) begin
            acc_next_s = {div_diff_s[31:0], div_shl_s[31:1], 1'b1};
         end else begin
            acc_next_s = div_shl_s[63:0];
         end
      end else begin
         acc_next_s = {mul_sum_s, acc_r[31:1]};
      end
   end

   // Sign correction and divide-by-zero handling of the final step's value.
   always_comb begin
      prod_s   = acc_next_s;
      quot_s   = acc_next_s[31:0];
      rem_s    = acc_next_s[63:32];
      res_hi_s = acc_next_s[63:32];
      res_lo_s = acc_next_s[31:0];
      if (op_r[1]) begin
         if (b_r == 32'd0) begin
            // Divide by zero: pass the dividend through, all-ones quotient.
            res_hi_s = a_r;
            res_lo_s = 32'hFFFF_FFFF;
         end else begin
            if (op_r[0] && (a_r[31] ^ b_r[31])) begin
               quot_s = neg32(acc_next_s[31:0]);
            end else begin
               quot_s = acc_next_s[31:0];
            end
            if (op_r[0] && a_r[31]) begin
               rem_s = neg32(acc_next_s[63:32]);
            end else begin
               rem_s = acc_next_s[63:32];
            end
            res_hi_s = rem_s;
            res_lo_s = quot_s;
         end
      end else begin
         if (op_r[0] && (a_r[31] ^ b_r[31])) begin
            prod_s = neg64(acc_next_s);
         end else begin
            prod_s = acc_next_s;
         end
         res_hi_s = prod_s[63:32];
         res_lo_s = prod_s[31:0];
      end
   end

   // Operand latch, working register and iteration counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r   <= 2'd0;
         a_r    <= 32'd0;
         b_r    <= 32'd0;
         acc_r  <= 64'd0;
         opnd_r <= 32'd0;
         cnt_r  <= 5'd0;
      end else if (load_s) begin
         op_r  <= op;
         a_r   <= A;
         b_r   <= B;
         cnt_r <= 5'd0;
         if (op[1]) begin
            acc_r  <= {32'd0, magnitude(A, op[0])};
            opnd_r <= magnitude(B, op[0]);
         end else begin
            acc_r  <= {32'd0, magnitude(B, op[0])};
            opnd_r <= magnitude(A, op[0]);
         end
      end else if (step_s) begin
         acc_r <= acc_next_s;
         cnt_r <= cnt_r + 5'd1;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   // Registered status flags and result, written on DONE entry only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= 32'd0;
         lo_r   <= 32'd0;
      end else begin
         busy_r <= (next_state_s == ST_RUN);
         done_r <= (next_state_s == ST_DONE);
         if (finish_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
         end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for mul_div_unit: stimulus pushes reference results,
// a negedge monitor checks busy/done timing and hi/lo every cycle.
module tb_mul_div_unit;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'd0;
   logic [31:0] A     = 32'd0;
   logic [31:0] B     = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          start_cyc;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] last_res = 64'd0;
   int          cyc   = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   mul_div_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock, 10 ns period.
   initial forever #5 clk = ~clk;

   // Rising-edge counter used to time expected events.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain 64-bit arithmetic, result as {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      int                 sa, sb2, q, r;
      logic [63:0]        res;
      res = 64'd0;
      case (o)
         2'b00: res = {32'd0, a} * {32'd0, b};
         2'b01: begin
            sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            res = sp;
         end
         2'b10: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
            else begin
               sa  = $signed(a);
               sb2 = $signed(b);
               q   = sa / sb2;
               r   = sa % sb2;
               res = {r, q};
            end
         end
      endcase
      return res;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic reset_check(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_hilo"}, {hi, lo}, 64'd0);
   endtask

   // Drive one start pulse just after a negedge; push the expectation if accepted.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit accept);
      exp_t        e;
      logic [63:0] r;
      @(negedge clk); #1;
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      if (accept) begin
         r           = model(o, a, b);
         e.hi        = r[63:32];
         e.lo        = r[31:0];
         e.start_cyc = cyc + 1;
         sbq.push_back(e);
      end
      @(negedge clk); #1;
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (sbq.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(sbq.size()), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'h8000_0000;
         3:       v = 32'd1;
         4:       v = 32'($urandom_range(0, 255));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: every negedge outside reset check busy, done and hi/lo.
   always @(negedge clk) begin
      logic exp_busy;
      logic exp_done;
      if (!rst) begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         if (sbq.size() > 0 && cyc > sbq[0].start_cyc + 32) begin
            n_vec++;
            n_bad++;
            $display("FAIL stale: actual no done by cycle %0d required done at %0d", cyc, sbq[0].start_cyc + 32);
            void'(sbq.pop_front());
         end
         if (sbq.size() > 0) begin
            if (cyc >= sbq[0].start_cyc && cyc <= sbq[0].start_cyc + 31) exp_busy = 1'b1;
            if (cyc == sbq[0].start_cyc + 32) exp_done = 1'b1;
         end
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         if (exp_done) begin
            last_res = {sbq[0].hi, sbq[0].lo};
            void'(sbq.pop_front());
         end
         chk("hilo", {hi, lo}, last_res);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: actual still running required finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      int unsigned g;
      logic [1:0]  ro;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2 reset_check("por");
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      // Max unsigned product, started on the first edge after reset release.
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // MULT then DIV issued in the DONE cycle.
      issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1);
      repeat (31) @(negedge clk);
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_idle();
      chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      issue(2'b10, 32'd100, 32'd0, 1'b1);
      wait_idle();
      chk("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_idle();
      chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);

      issue(2'b11, 32'hFFFF_FFF0, 32'd0, 1'b1);
      wait_idle();
      chk("div_by0", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);

      // Start while busy must be ignored.
      issue(2'b00, 32'd5, 32'd6, 1'b1);
      repeat (8) @(negedge clk);
      issue(2'b10, 32'd9, 32'd3, 1'b0);
      wait_idle();
      chk("ignored_start", {hi, lo}, 64'd30);
      repeat (5) @(negedge clk);

      // Reset mid-run aborts the operation.
      issue(2'b10, 32'd1000, 32'd7, 1'b1);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 reset_check("midrun");
      sbq.delete();
      last_res = 64'd0;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(2'b10, 32'd1000, 32'd7, 1'b1);
      wait_idle();
      chk("divu_1000_7", {hi, lo}, {32'd6, 32'd142});

      // Randomized operations, sometimes back-to-back.
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         issue(ro, pick(), pick(), 1'b1);
         g = $urandom_range(0, 3);
         repeat (31 + g) @(negedge clk);
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
